// File: rtl/led_refresh_ctrl.sv
// LED frame refresh sequencer: fetches FRAME_BYTES bytes from a shared single-port
// byte RAM, hands them to the LED shifter, enforces the latch gap and arbitrates host writes.
module led_refresh_ctrl #(
    parameter int unsigned LED_CNT   = 14,
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned RESET_CYC = 2500,
    parameter int unsigned CNT_W     = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_req_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [7:0]        wr_data_i,
    output logic              wr_ack_o,
    input  logic              commit_i,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    input  logic [7:0]        mem_rdata_i,
    output logic              tx_valid_o,
    output logic [7:0]        tx_data_o,
    input  logic              tx_ready_i,
    input  logic              tx_idle_i
);

    localparam int unsigned       FRAME_BYTES = LED_CNT * 3;
    localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(FRAME_BYTES - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST    = CNT_W'(RESET_CYC - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_SEND    = 3'd3;
    localparam logic [2:0] S_LATCH   = 3'd4;

    logic [2:0]        state_q,      state_d;
    logic [ADDR_W-1:0] byte_idx_q,   byte_idx_d;
    logic [CNT_W-1:0]  gap_cnt_q,    gap_cnt_d;
    logic              gap_run_q,    gap_run_d;
    logic              pending_q,    pending_d;
    logic              wr_ack_q,     wr_ack_d;
    logic              busy_q,       busy_d;
    logic              frame_done_q, frame_done_d;
    logic              mem_en_q,     mem_en_d;
    logic              mem_we_q,     mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic [7:0]        mem_wdata_q,  mem_wdata_d;
    logic              tx_valid_q,   tx_valid_d;
    logic [7:0]        tx_data_q,    tx_data_d;

    // Next-state, datapath and RAM-port arbitration
    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        gap_cnt_d    = gap_cnt_q;
        gap_run_d    = gap_run_q;
        pending_d    = pending_q | (commit_i & (state_q != S_IDLE));
        wr_ack_d     = 1'b0;
        frame_done_d = 1'b0;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        tx_valid_d   = tx_valid_q;
        tx_data_d    = tx_data_q;

        case (state_q)
            S_IDLE: begin
                if (commit_i || pending_q) begin
                    pending_d  = 1'b0;
                    byte_idx_d = '0;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                tx_data_d  = mem_rdata_i;
                tx_valid_d = 1'b1;
                state_d    = S_SEND;
            end
            S_SEND: begin
                if (tx_ready_i) begin
                    tx_valid_d = 1'b0;
                    if (byte_idx_q == LAST_IDX) begin
                        gap_run_d = 1'b0;
                        gap_cnt_d = '0;
                        state_d   = S_LATCH;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        state_d    = S_FETCH;
                    end
                end
            end
            S_LATCH: begin
                // Gap count starts only once the shifter has drained the line
                if (!gap_run_q) begin
                    if (tx_idle_i) begin
                        gap_run_d = 1'b1;
                        gap_cnt_d = '0;
                    end
                end else if (gap_cnt_q == GAP_LAST) begin
                    gap_run_d    = 1'b0;
                    gap_cnt_d    = '0;
                    frame_done_d = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The port access happens in the cycle after this edge, so decide on state_d
        if (state_d == S_FETCH) begin
            mem_en_d   = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = byte_idx_d;
        end else if (wr_req_i && !wr_ack_q) begin
            wr_ack_d = 1'b1;
            if (wr_addr_i <= LAST_IDX) begin
                mem_en_d    = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = wr_addr_i;
                mem_wdata_d = wr_data_i;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            byte_idx_q   <= '0;
            gap_cnt_q    <= '0;
            gap_run_q    <= 1'b0;
            pending_q    <= 1'b0;
            wr_ack_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            gap_cnt_q    <= gap_cnt_d;
            gap_run_q    <= gap_run_d;
            pending_q    <= pending_d;
            wr_ack_q     <= wr_ack_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
        end
    end

    assign wr_ack_o     = wr_ack_q;
    assign busy_o       = busy_q;
    assign frame_done_o = frame_done_q;
    assign mem_en_o     = mem_en_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign tx_valid_o   = tx_valid_q;
    assign tx_data_o    = tx_data_q;

endmodule
